// File: rtl/confetti_animator_pkg.sv
`default_nettype none
//==============================================================================
// Module : confetti_animator_pkg
// Brief  : Shared types, sizes and state encoding for the confetti animator.
// Rev    : 1.0  initial release
//==============================================================================
package confetti_animator_pkg;

    localparam int unsigned MAX_CONFETTI = 101;
    localparam int unsigned NUM_CONFETTI = 51;
    localparam int unsigned SCREEN_ROWS  = 480;
    localparam int unsigned SCREEN_COLS  = 640;

    typedef struct packed {
        logic [31:0] rowstart;
        logic [31:0] colstart;
        logic [31:0] width;
        logic [31:0] length;
    } confetti_struct;

    typedef confetti_struct [MAX_CONFETTI-1:0] confetti_array_t;

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_LOAD       = 2'd1;
    localparam logic [1:0] c_ST_WAIT_FRAME = 2'd2;
    localparam logic [1:0] c_ST_UPDATE     = 2'd3;

    // Fall speed depends only on the entry index modulo 4.
    function automatic logic [31:0] fall_speed(input logic [1:0] idx_lsbs);
        return 32'(idx_lsbs) + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/confetti_animator_if.sv
`default_nettype none
//==============================================================================
// Module : confetti_animator_if
// Brief  : Control pulses, seed table and animated position table bundle.
// Rev    : 1.0  initial release
//==============================================================================
interface confetti_animator_if;
    import confetti_animator_pkg::*;

    logic            start;
    logic            stop;
    logic            frame_tick;
    confetti_array_t seed_array;
    confetti_array_t confetti_array;
    logic            active;
    logic            busy;
    logic            frame_done;
    logic            overrun;

    modport master (
        output start, stop, frame_tick, seed_array,
        input  confetti_array, active, busy, frame_done, overrun
    );

    modport slave (
        input  start, stop, frame_tick, seed_array,
        output confetti_array, active, busy, frame_done, overrun
    );

endinterface
`default_nettype wire

// File: rtl/confetti_step.sv
`default_nettype none
//==============================================================================
// Module : confetti_step
// Brief  : Combinational next-position of one confetti entry (fall + drift).
// Rev    : 1.0  initial release
//==============================================================================
module confetti_step #(
    parameter int unsigned SCREEN_ROWS = confetti_animator_pkg::SCREEN_ROWS,
    parameter int unsigned SCREEN_COLS = confetti_animator_pkg::SCREEN_COLS
) (
    input  confetti_animator_pkg::confetti_struct entry,
    input  logic [6:0]                            idx,
    input  logic [31:0]                           fcnt,
    output confetti_animator_pkg::confetti_struct next_entry
);
    import confetti_animator_pkg::*;

    localparam logic [31:0] c_ROWS     = 32'(SCREEN_ROWS);
    localparam logic [31:0] c_COL_LAST = 32'(SCREEN_COLS - 1);

    logic [31:0] w_row_sum;
    logic        w_drift_right;
    logic        w_unused;

    assign w_row_sum     = entry.rowstart + fall_speed(idx[1:0]);
    assign w_drift_right = idx[0] ^ fcnt[0];
    assign w_unused      = ^{idx[6:2], fcnt[31:1]};

    always_comb begin
        next_entry          = entry;
        next_entry.rowstart = (w_row_sum >= c_ROWS) ? (w_row_sum - c_ROWS) : w_row_sum;
        if (w_drift_right) begin
            next_entry.colstart = (entry.colstart == c_COL_LAST) ? 32'd0 : (entry.colstart + 32'd1);
        end else begin
            next_entry.colstart = (entry.colstart == 32'd0) ? c_COL_LAST : (entry.colstart - 32'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/confetti_animator.sv
`default_nettype none
//==============================================================================
// Module : confetti_animator
// Brief  : Per-frame sweep that moves each confetti entry one step per cycle.
// Rev    : 1.0  initial release
//==============================================================================
module confetti_animator #(
    parameter int unsigned NUM_CONFETTI = confetti_animator_pkg::NUM_CONFETTI,
    parameter int unsigned SCREEN_ROWS  = confetti_animator_pkg::SCREEN_ROWS,
    parameter int unsigned SCREEN_COLS  = confetti_animator_pkg::SCREEN_COLS
) (
    input  wire                        clk,
    input  wire                        reset,
    confetti_animator_if.slave         bus
);
    import confetti_animator_pkg::*;

    localparam logic [6:0] c_LAST_IDX = 7'(NUM_CONFETTI - 1);

    logic [1:0]      r_state;
    logic [6:0]      r_idx;
    logic [31:0]     r_fcnt;
    logic            r_overrun;
    logic            r_frame_done;
    logic            r_busy;
    logic            r_active;
    confetti_array_t r_conf;
    confetti_struct  w_next;

    confetti_step #(
        .SCREEN_ROWS (SCREEN_ROWS),
        .SCREEN_COLS (SCREEN_COLS)
    ) u_step (
        .entry      (r_conf[r_idx]),
        .idx        (r_idx),
        .fcnt       (r_fcnt),
        .next_entry (w_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= 7'd0;
            r_fcnt       <= 32'd0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_active     <= 1'b0;
            r_conf       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            // Stop outranks start; either one abandons a sweep in flight.
            if (bus.stop) begin
                r_state  <= c_ST_IDLE;
                r_idx    <= 7'd0;
                r_busy   <= 1'b0;
                r_active <= 1'b0;
            end else if (bus.start) begin
                r_state  <= c_ST_LOAD;
                r_idx    <= 7'd0;
                r_busy   <= 1'b0;
                r_active <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_busy   <= 1'b0;
                        r_active <= 1'b0;
                    end
                    c_ST_LOAD: begin
                        for (int i = 0; i < int'(MAX_CONFETTI); i++) begin
                            r_conf[i] <= (i < int'(NUM_CONFETTI)) ? bus.seed_array[i] : '0;
                        end
                        r_fcnt    <= 32'd0;
                        r_overrun <= 1'b0;
                        r_state   <= c_ST_WAIT_FRAME;
                    end
                    c_ST_WAIT_FRAME: begin
                        if (bus.frame_tick) begin
                            r_state <= c_ST_UPDATE;
                            r_idx   <= 7'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                    c_ST_UPDATE: begin
                        r_conf[r_idx] <= w_next;
                        if (bus.frame_tick) begin
                            r_overrun <= 1'b1;
                        end
                        if (r_idx == c_LAST_IDX) begin
                            r_state      <= c_ST_WAIT_FRAME;
                            r_idx        <= 7'd0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_fcnt       <= r_fcnt + 32'd1;
                        end else begin
                            r_idx <= r_idx + 7'd1;
                        end
                    end
                    default: begin
                        r_state  <= c_ST_IDLE;
                        r_busy   <= 1'b0;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.confetti_array = r_conf;
    assign bus.active         = r_active;
    assign bus.busy           = r_busy;
    assign bus.frame_done     = r_frame_done;
    assign bus.overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_confetti_animator.sv
`default_nettype none
//==============================================================================
// Module : tb_confetti_animator
// Brief  : Random-stimulus bench with a closed-form position model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_confetti_animator;
    import confetti_animator_pkg::*;

    localparam int N    = 51;
    localparam int ROWS = 480;
    localparam int COLS = 640;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    confetti_animator_if bus();

    confetti_animator #(
        .NUM_CONFETTI (N),
        .SCREEN_ROWS  (ROWS),
        .SCREEN_COLS  (COLS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Model: an entry's position is a function of its seed and how many
    // updates it has received since the last load.
    bit             m_loaded;
    bit             m_running;
    bit             m_loading;
    bit             m_done;
    bit             m_overrun;
    int             m_pos;
    int             m_steps [MAX_CONFETTI];
    confetti_struct m_seed  [MAX_CONFETTI];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    function automatic confetti_struct exp_entry(input int i);
        confetti_struct e;
        longint sp;
        longint net;
        e = '0;
        if (m_loaded && i < N) begin
            sp  = 1 + (i % 4);
            net = 0;
            if (m_steps[i] % 2 == 1) net = (i % 2 == 1) ? 1 : -1;
            e.rowstart = 32'((longint'(m_seed[i].rowstart) + longint'(m_steps[i]) * sp) % ROWS);
            e.colstart = 32'((longint'(m_seed[i].colstart) + net + COLS) % COLS);
            e.width    = m_seed[i].width;
            e.length   = m_seed[i].length;
        end
        return e;
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (reset) begin
            m_loaded = 0; m_running = 0; m_loading = 0; m_overrun = 0; m_pos = -1;
            for (int i = 0; i < int'(MAX_CONFETTI); i++) m_steps[i] = 0;
        end else if (bus.stop) begin
            m_running = 0; m_loading = 0; m_pos = -1;
        end else if (bus.start) begin
            m_running = 1; m_loading = 1; m_pos = -1;
        end else if (m_loading) begin
            m_loading = 0; m_loaded = 1; m_overrun = 0;
            for (int i = 0; i < int'(MAX_CONFETTI); i++) begin
                m_seed[i]  = bus.seed_array[i];
                m_steps[i] = 0;
            end
        end else if (m_pos >= 0) begin
            m_steps[m_pos]++;
            if (bus.frame_tick) m_overrun = 1;
            m_pos++;
            if (m_pos == N) begin
                m_pos  = -1;
                m_done = 1;
            end
        end else if (m_running && bus.frame_tick) begin
            m_pos = 0;
        end
    endtask

    task automatic check_all();
        int bad;
        confetti_struct e;
        chk("active", longint'(bus.active), longint'(m_running));
        chk("busy", longint'(bus.busy), longint'(m_pos >= 0));
        chk("frame_done", longint'(bus.frame_done), longint'(m_done));
        chk("overrun", longint'(bus.overrun), longint'(m_overrun));
        bad = -1;
        for (int i = 0; i < int'(MAX_CONFETTI); i++) begin
            e = exp_entry(i);
            if (bad < 0 && bus.confetti_array[i] !== e) bad = i;
        end
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL confetti_array[%0d] actual=%h required=%h at %0t",
                      bad, bus.confetti_array[bad], exp_entry(bad), $time);
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit t);
        reset = r; bus.start = s; bus.stop = p; bus.frame_tick = t;
        model_step();
        @(posedge clk);
        #1;
        check_all();
        reset = 0; bus.start = 0; bus.stop = 0; bus.frame_tick = 0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!bus.frame_done && k < budget) begin
            step(0, 0, 0, 0);
            k++;
        end
        chk("frame_done_within_budget", longint'(bus.frame_done), 1);
    endtask

    task automatic randomize_seeds();
        for (int i = 0; i < int'(MAX_CONFETTI); i++) begin
            bus.seed_array[i].rowstart = $urandom_range(ROWS - 1, 0);
            bus.seed_array[i].colstart = $urandom_range(COLS - 1, 0);
            bus.seed_array[i].width    = $urandom;
            bus.seed_array[i].length   = $urandom;
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        reset = 0; bus.start = 0; bus.stop = 0; bus.frame_tick = 0;
        m_loaded = 0; m_running = 0; m_loading = 0; m_done = 0; m_overrun = 0; m_pos = -1;
        for (int i = 0; i < int'(MAX_CONFETTI); i++) m_steps[i] = 0;
        randomize_seeds();
        bus.seed_array[0] = '{rowstart: 32'd50,  colstart: 32'd50,  width: 32'd5, length: 32'd5};
        bus.seed_array[1] = '{rowstart: 32'd80,  colstart: 32'd639, width: 32'd5, length: 32'd5};
        bus.seed_array[3] = '{rowstart: 32'd478, colstart: 32'd10,  width: 32'd5, length: 32'd5};

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_active", longint'(bus.active), 0);
        chk("reset_row0", longint'(bus.confetti_array[0].rowstart), 0);

        // Load, with a frame_tick coinciding with the load cycle.
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("tick_in_load_ignored", longint'(bus.busy), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        wait_done(60);
        chk("e0_row_f1", longint'(bus.confetti_array[0].rowstart), 51);
        chk("e0_col_f1", longint'(bus.confetti_array[0].colstart), 49);
        chk("e0_width_f1", longint'(bus.confetti_array[0].width), 5);
        chk("e3_row_wrap", longint'(bus.confetti_array[3].rowstart), 2);
        chk("e3_col_f1", longint'(bus.confetti_array[3].colstart), 11);
        chk("e1_col_wrap_hi", longint'(bus.confetti_array[1].colstart), 0);
        chk("active_f1", longint'(bus.active), 1);

        step(0, 0, 0, 1);
        wait_done(60);
        chk("e1_col_wrap_lo", longint'(bus.confetti_array[1].colstart), 639);

        // Second tick ten cycles into a sweep.
        busy_cnt = 0; done_cnt = 0;
        step(0, 0, 0, 1);
        busy_cnt += int'(bus.busy);
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, 0);
            busy_cnt += int'(bus.busy);
        end
        step(0, 0, 0, 1);
        busy_cnt += int'(bus.busy);
        for (int k = 0; k < 60; k++) begin
            step(0, 0, 0, 0);
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.frame_done);
        end
        chk("overrun_busy_cycles", busy_cnt, 51);
        chk("overrun_done_pulses", done_cnt, 1);
        chk("overrun_sticky", longint'(bus.overrun), 1);

        // Stop while entry 20 is the next to update.
        step(0, 0, 0, 1);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("stop_active", longint'(bus.active), 0);
        chk("stop_e0_row", longint'(bus.confetti_array[0].rowstart), 54);
        chk("stop_e0_col", longint'(bus.confetti_array[0].colstart), 50);
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            step(0, 0, 0, (k == 5));
            done_cnt += int'(bus.frame_done);
        end
        chk("stop_no_done", done_cnt, 0);

        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("reload_e0_row", longint'(bus.confetti_array[0].rowstart), 50);
        chk("reload_e0_col", longint'(bus.confetti_array[0].colstart), 50);
        chk("reload_overrun", longint'(bus.overrun), 0);

        // Reset in the middle of a sweep.
        step(0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_mid_busy", longint'(bus.busy), 0);
        chk("rst_mid_row0", longint'(bus.confetti_array[0].rowstart), 0);
        for (int k = 0; k < 60; k++) step(0, 0, 0, 0);

        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        chk("start_stop_idle", longint'(bus.active), 0);

        // Randomized traffic.
        for (int k = 0; k < 6000; k++) begin
            bit r, s, p, t;
            if ($urandom_range(99, 0) == 0) randomize_seeds();
            r = ($urandom_range(999, 0) < 1);
            s = m_running ? ($urandom_range(999, 0) < 4) : ($urandom_range(99, 0) < 5);
            p = ($urandom_range(999, 0) < 3);
            t = ($urandom_range(99, 0) < 4);
            step(r, s, p, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
